fifo_pop_packer: RTL and testbench

- Sits directly downstream of the parameterized push/pop FIFO.
- Drains the FIFO one narrow word per pop and packs RATIO words into one wide beat on a valid/ready output stream.
- Partial beats are emitted on an idle timeout or on an explicit flush, with a per-lane keep mask.
- Feeds the wide-bus consumer stage.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/pop_packer_idle_timer.sv | 31 +++
 rtl/fifo_pop_packer.sv | 114 +++++++++++
 tb/tb_fifo_pop_packer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the narrow FIFO and the pop packer behind it.
// Holds the packer FSM encoding and the FIFO push/pop case enum.
package fifo_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_t;

    typedef enum logic [1:0] {
        FIFO_NOP      = 2'b00,
        FIFO_PUSH     = 2'b01,
        FIFO_POP      = 2'b10,
        FIFO_PUSH_POP = 2'b11
    } fifo_op_t;

    function automatic fifo_op_t fifo_op(input logic push, input logic pop);
        return fifo_op_t'({pop, push});
    endfunction

endpackage

// File: rtl/pop_packer_idle_timer.sv
// Counts consecutive idle cycles while a partial beat is held.
// expire pulses on the cycle the count reaches TIMEOUT-1.
module pop_packer_idle_timer
    import fifo_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] count;

    assign expire = count_en && !clear && (count == IW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + IW'(1);
        end
    end

endmodule

// File: rtl/fifo_pop_packer.sv
// Drains a narrow FIFO and packs RATIO words into one wide beat.
// Partial beats leave on idle timeout or flush, with a keep mask.
module fifo_pop_packer
    import fifo_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fifo_empty_i,
    output logic                    fifo_pop_o,
    input  logic [DATA_W-1:0]       fifo_pop_data_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_W*RATIO-1:0] out_data_o,
    output logic [RATIO-1:0]        out_keep_o
);

    localparam int CW = $clog2(RATIO);

    pack_state_t              state_q;
    pack_state_t              state_d;
    logic [CW-1:0]            cnt_q;
    logic [DATA_W*RATIO-1:0]  data_q;
    logic [RATIO-1:0]         keep_q;

    logic in_fill;
    logic has_data;
    logic last_lane;
    logic flush_go;
    logic fire;
    logic expire;
    logic tmr_clear;
    logic tmr_en;

    assign in_fill   = (state_q == ST_FILL);
    assign has_data  = (cnt_q != '0);
    assign last_lane = (cnt_q == CW'(RATIO - 1));
    assign flush_go  = in_fill && flush_i && has_data;
    assign fire      = out_valid_o && out_ready_i;

    assign tmr_clear = !in_fill || !has_data || fifo_pop_o;
    assign tmr_en    = in_fill && has_data && fifo_empty_i && !flush_i;

    pop_packer_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (tmr_clear),
        .count_en (tmr_en),
        .expire   (expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL: begin
                if ((fifo_pop_o && last_lane) || flush_go || expire) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    state_d = ST_FILL;
                end
            end
        endcase
    end

    // Pop is gated by reset so nothing is lost while the block is held.
    always_comb begin
        out_valid_o = (state_q == ST_HOLD);
        fifo_pop_o  = in_fill && !reset && !fifo_empty_i
                      && !(flush_i && has_data);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            data_q <= '0;
            keep_q <= '0;
        end else if (fire) begin
            cnt_q  <= '0;
            data_q <= '0;
            keep_q <= '0;
        end else if (fifo_pop_o) begin
            for (int k = 0; k < RATIO; k++) begin
                if (cnt_q == CW'(k)) begin
                    data_q[k*DATA_W +: DATA_W] <= fifo_pop_data_i;
                    keep_q[k]                  <= 1'b1;
                end
            end
            cnt_q <= last_lane ? '0 : cnt_q + CW'(1);
        end else if (flush_go || expire) begin
            cnt_q <= '0;
        end
    end

    assign out_data_o = data_q;
    assign out_keep_o = keep_q;

endmodule

// File: tb/tb_fifo_pop_packer.sv
// Bench for fifo_pop_packer: queue FIFO in front, word-list model,
// directed scenarios followed by randomized push/flush/ready traffic.
module tb_fifo_pop_packer;

    localparam int DATA_W  = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;

    logic        clock;
    logic        reset;
    logic        fifo_empty_i;
    logic        fifo_pop_o;
    logic [7:0]  fifo_pop_data_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [3:0]  out_keep_o;

    fifo_pop_packer #(
        .DATA_W  (DATA_W),
        .RATIO   (RATIO),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_pop_o      (fifo_pop_o),
        .fifo_pop_data_i (fifo_pop_data_i),
        .flush_i         (flush_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .out_keep_o      (out_keep_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int beats = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  m_words[$];
    bit          m_hold;
    int          m_idle;
    logic [31:0] m_data;
    logic [3:0]  m_keep;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Beat is the words in pop order, lane 0 first, unused lanes zero.
    task automatic emit();
        m_data = '0;
        for (int k = 0; k < m_words.size(); k++) begin
            m_data = m_data | (32'(m_words[k]) << (8 * k));
        end
        m_keep = 4'((1 << m_words.size()) - 1);
        m_hold = 1'b1;
        m_idle = 0;
        m_words.delete();
    endtask

    task automatic cycle(input bit do_push, input logic [7:0] w,
                         input bit fl, input bit rdy);
        bit         dut_pop;
        bit         exp_pop;
        logic [7:0] head;
        if (do_push) fifo_q.push_back(w);
        fifo_empty_i    = (fifo_q.size() == 0);
        head            = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        fifo_pop_data_i = head;
        flush_i         = fl;
        out_ready_i     = rdy;
        #1;
        exp_pop = !m_hold && !fifo_empty_i && !(fl && m_words.size() != 0);
        chk("pop", 32'(fifo_pop_o), 32'(exp_pop));
        chk("valid", 32'(out_valid_o), 32'(m_hold));
        if (m_hold) begin
            chk("data", out_data_o, m_data);
            chk("keep", 32'(out_keep_o), 32'(m_keep));
        end
        dut_pop = fifo_pop_o;
        if (out_valid_o && rdy) beats++;
        if (m_hold) begin
            if (rdy) m_hold = 1'b0;
        end else if (exp_pop) begin
            m_words.push_back(head);
            m_idle = 0;
            if (m_words.size() == RATIO) emit();
        end else if (fl && m_words.size() != 0) begin
            emit();
        end else if (m_words.size() != 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) emit();
        end
        @(posedge clock);
        if (dut_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        @(negedge clock);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, rdy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_keep", 32'(out_keep_o), 32'd0);
        chk("rst_data", out_data_o, 32'd0);
        chk("rst_pop", 32'(fifo_pop_o), 32'd0);
        m_hold = 1'b0;
        m_idle = 0;
        m_words.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        fifo_empty_i    = 1'b1;
        fifo_pop_data_i = 8'h00;
        flush_i         = 1'b0;
        out_ready_i     = 1'b0;
        m_hold          = 1'b0;
        m_idle          = 0;
        m_data          = '0;
        m_keep          = '0;
        do_reset();

        // full beat
        beats = 0;
        cycle(1'b1, 8'h11, 1'b0, 1'b1);
        cycle(1'b1, 8'h22, 1'b0, 1'b1);
        cycle(1'b1, 8'h33, 1'b0, 1'b1);
        cycle(1'b1, 8'h44, 1'b0, 1'b1);
        idle(4, 1'b1);
        chk("t1_beats", 32'(beats), 32'd1);

        // idle timeout, held a few cycles before ready
        beats = 0;
        cycle(1'b1, 8'hA1, 1'b0, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0, 1'b0);
        idle(20, 1'b0);
        idle(3, 1'b1);
        chk("t2_beats", 32'(beats), 32'd1);

        // flush of a partial beat, then flushes with nothing packed
        beats = 0;
        cycle(1'b1, 8'h05, 1'b0, 1'b1);
        idle(1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        idle(2, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("t3_beats", 32'(beats), 32'd1);

        // backpressure with two beats queued
        beats = 0;
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(8, 1'b1);
        chk("t4_beats", 32'(beats), 32'd2);
        chk("t4_fifo_empty", 32'(fifo_q.size()), 32'd0);

        // reset mid-beat discards packed lanes
        beats = 0;
        cycle(1'b1, 8'h71, 1'b0, 1'b1);
        cycle(1'b1, 8'h72, 1'b0, 1'b1);
        cycle(1'b1, 8'h73, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b1);
        idle(2, 1'b1);
        chk("t5_beats", 32'(beats), 32'd1);

        // empty FIFO with flush noise
        beats = 0;
        for (int i = 0; i < 50; i++)
            cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b1);
        chk("t6_beats", 32'(beats), 32'd0);

        // randomized traffic, alternating dense and sparse pushes
        for (int s = 0; s < 6; s++) begin
            int den;
            den = (s % 2 == 0) ? 2 : 24;
            for (int i = 0; i < 300; i++) begin
                cycle($urandom_range(0, den - 1) == 0, 8'($urandom),
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 3) != 0);
            end
        end
        idle(30, 1'b1);
        chk("rand_fifo_empty", 32'(fifo_q.size()), 32'd0);
        chk("rand_idle", 32'(out_valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
